// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state type and default parameters for the batch sequencer
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    RESULT
  } batch_state_t;

  localparam int LOGDEPTH_DEF = 6;
  localparam int WIDTH_DEF    = 32;
  localparam int TIMEOUT_DEF  = 256;

endpackage

// File: rtl/beat_watchdog.sv
// rtl/beat_watchdog.sv - idle-cycle counter that flags TIMEOUT consecutive enabled cycles
module beat_watchdog #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The cycle that would be the TIMEOUT-th without a beat is the one that fires.
  assign expired = enable && !clear && (cnt_q == LIMIT);

endmodule

// File: rtl/mult_batch_ctrl.sv
// rtl/mult_batch_ctrl.sv - feeds one batch of operand pairs to the multiplier and sums the read-back
module mult_batch_ctrl
  import mult_pkg::*;
#(
  parameter int LOGDEPTH = LOGDEPTH_DEF,
  parameter int WIDTH    = WIDTH_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_start,
  output logic                      busy,
  input  logic                      op_valid,
  output logic                      op_ready,
  input  logic [15:0]               op_a,
  input  logic [15:0]               op_b,
  output logic                      EN_mult,
  output logic [15:0]               mult_input0,
  output logic [15:0]               mult_input1,
  input  logic                      RDY_mult,
  output logic                      EN_blockRead,
  input  logic                      VALID_memVal,
  input  logic [WIDTH-1:0]          memVal_data,
  output logic                      result_valid,
  input  logic                      result_ready,
  output logic [WIDTH+LOGDEPTH-1:0] result_data,
  output logic [LOGDEPTH:0]         result_count,
  output logic                      err_timeout
);

  localparam int CW = LOGDEPTH + 1;
  localparam int AW = WIDTH + LOGDEPTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(2 ** LOGDEPTH);
  localparam logic [CW-1:0] LAST_C  = DEPTH_C - CW'(1);

  batch_state_t  state_q, state_d;
  logic [CW-1:0] issued_q, issued_d;
  logic [CW-1:0] beats_q, beats_d;
  logic [AW-1:0] acc_q, acc_d;
  logic          err_q, err_d;
  logic          blkrd_q, blkrd_d;
  logic          accept, beat, wd_expired;

  assign accept      = op_valid && op_ready;
  assign beat        = (state_q == DRAIN) && VALID_memVal && (beats_q < DEPTH_C);
  assign EN_mult     = accept;
  assign mult_input0 = op_a;
  assign mult_input1 = op_b;

  beat_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   ((state_q != DRAIN) || beat),
    .enable  (state_q == DRAIN),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      issued_q <= '0;
      beats_q  <= '0;
      acc_q    <= '0;
      err_q    <= 1'b0;
      blkrd_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      beats_q  <= beats_d;
      acc_q    <= acc_d;
      err_q    <= err_d;
      blkrd_q  <= blkrd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    issued_d = issued_q;
    beats_d  = beats_q;
    acc_d    = acc_q;
    err_d    = err_q;
    blkrd_d  = blkrd_q;
    case (state_q)
      IDLE: begin
        if (cmd_start) begin
          state_d  = FEED;
          issued_d = '0;
          beats_d  = '0;
          acc_d    = '0;
          err_d    = 1'b0;
        end
      end
      FEED: begin
        if (accept) begin
          issued_d = issued_q + CW'(1);
          if (issued_q == LAST_C) begin
            state_d = DRAIN;
            blkrd_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        // A beat in the expiry cycle wins: it proves the source is still alive.
        if (beat) begin
          acc_d   = acc_q + AW'(memVal_data);
          beats_d = beats_q + CW'(1);
          blkrd_d = 1'b0;
          if (beats_q == LAST_C) begin
            state_d = RESULT;
          end
        end else if (wd_expired) begin
          state_d = RESULT;
          err_d   = 1'b1;
          blkrd_d = 1'b0;
        end
      end
      RESULT: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q != IDLE);
    op_ready     = (state_q == FEED) && RDY_mult && (issued_q < DEPTH_C);
    result_valid = (state_q == RESULT);
    EN_blockRead = blkrd_q;
    result_data  = acc_q;
    result_count = beats_q;
    err_timeout  = err_q;
  end

endmodule

// File: tb/tb_mult_batch_ctrl.sv
// tb/tb_mult_batch_ctrl.sv - directed and randomized batches checked against an arithmetic model
module tb_mult_batch_ctrl;

  localparam int LD    = 6;
  localparam int W     = 32;
  localparam int TO    = 256;
  localparam int DEPTH = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_start;
  logic            busy;
  logic            op_valid;
  logic            op_ready;
  logic [15:0]     op_a, op_b;
  logic            EN_mult;
  logic [15:0]     mult_input0, mult_input1;
  logic            RDY_mult;
  logic            EN_blockRead;
  logic            VALID_memVal;
  logic [W-1:0]    memVal_data;
  logic            result_valid;
  logic            result_ready;
  logic [W+LD-1:0] result_data;
  logic [LD:0]     result_count;
  logic            err_timeout;

  int checks = 0;
  int errors = 0;
  logic [15:0] a_arr [DEPTH];
  logic [15:0] b_arr [DEPTH];
  logic [63:0] exp_sum;

  always #5 clk = ~clk;

  mult_batch_ctrl #(.LOGDEPTH(LD), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_start    (cmd_start),
    .busy         (busy),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .EN_mult      (EN_mult),
    .mult_input0  (mult_input0),
    .mult_input1  (mult_input1),
    .RDY_mult     (RDY_mult),
    .EN_blockRead (EN_blockRead),
    .VALID_memVal (VALID_memVal),
    .memVal_data  (memVal_data),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_data  (result_data),
    .result_count (result_count),
    .err_timeout  (err_timeout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < DEPTH; i++) begin
      case (mode)
        0:       begin a_arr[i] = 16'(i + 1); b_arr[i] = 16'd2; end
        1:       begin a_arr[i] = 16'hFFFF;   b_arr[i] = 16'hFFFF; end
        default: begin a_arr[i] = 16'($urandom); b_arr[i] = 16'($urandom); end
      endcase
    end
  endtask

  task automatic start_batch();
    op_valid  = 1'b0;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    #1;
    check("busy_after_start", busy, 1);
  endtask

  task automatic feed(input bit bp);
    int fed = 0;
    int cyc = 0;
    int stall = 0;
    bit dropped = 1'b0;
    while (fed < DEPTH && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (bp && fed == 20 && !dropped) begin
        stall = 10;
        dropped = 1'b1;
      end
      RDY_mult = (stall == 0);
      if (stall > 0) stall--;
      op_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      op_a = a_arr[fed];
      op_b = b_arr[fed];
      #1;
      check("en_mult", EN_mult, op_valid && RDY_mult);
      check("op_ready", op_ready, RDY_mult);
      if (EN_mult) begin
        check("mult_input0", mult_input0, a_arr[fed]);
        check("mult_input1", mult_input1, b_arr[fed]);
        fed++;
      end
    end
    check("feed_pulses", fed, DEPTH);
    @(negedge clk);
    op_valid = 1'b1;
    RDY_mult = 1'b1;
    #1;
    check("drain_blockread", EN_blockRead, 1);
    check("drain_op_ready", op_ready, 0);
    check("drain_en_mult", EN_mult, 0);
    op_valid = 1'b0;
  endtask

  // Acts as the multiplier's read-out: returns a*b in issue order, leaves VALID high on the last beat.
  task automatic drain(input int nbeats, input bit gaps);
    exp_sum = 0;
    for (int k = 0; k < nbeats; k++) begin
      repeat (gaps ? $urandom_range(0, 3) : 0) begin
        @(negedge clk);
        VALID_memVal = 1'b0;
      end
      @(negedge clk);
      #1;
      if (k == 1) check("blockread_cleared", EN_blockRead, 0);
      VALID_memVal = 1'b1;
      memVal_data  = 32'(a_arr[k]) * 32'(b_arr[k]);
      exp_sum      = exp_sum + 64'(memVal_data);
    end
  endtask

  task automatic check_result(input logic [63:0] sum, input int cnt, input bit err,
                              input int stall, input bit strays);
    check("result_valid", result_valid, 1);
    check("result_data", result_data, sum);
    check("result_count", result_count, cnt);
    check("err_timeout", err_timeout, err);
    if (!result_ready) begin
      repeat (stall) begin
        @(negedge clk);
        if (strays) begin
          cmd_start    = 1'($urandom_range(0, 1));
          VALID_memVal = 1'($urandom_range(0, 1));
          memVal_data  = $urandom;
        end
        #1;
        check("stall_valid", result_valid, 1);
        check("stall_data", result_data, sum);
        check("stall_count", result_count, cnt);
        check("stall_err", err_timeout, err);
      end
      @(negedge clk);
      result_ready = 1'b1;
      cmd_start    = strays;
      VALID_memVal = 1'b0;
      #1;
      check("handoff_valid", result_valid, 1);
    end
    @(negedge clk);
    cmd_start    = 1'b0;
    VALID_memVal = 1'b0;
    #1;
    check("idle_busy", busy, 0);
    check("idle_result_valid", result_valid, 0);
    check("idle_blockread", EN_blockRead, 0);
  endtask

  task automatic finish_full(input int stall, input bit strays);
    @(negedge clk);
    VALID_memVal = 1'b0;
    #1;
    check_result(exp_sum, DEPTH, 1'b0, stall, strays);
  endtask

  initial begin
    int n;
    rst = 1'b1; cmd_start = 1'b0; op_valid = 1'b1; RDY_mult = 1'b1;
    op_a = 16'h1234; op_b = 16'h5678; VALID_memVal = 1'b0; memVal_data = '0;
    result_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_op_ready", op_ready, 0);
    check("rst_en_mult", EN_mult, 0);
    check("rst_blockread", EN_blockRead, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_err", err_timeout, 0);
    check("rst_data", result_data, 0);
    check("rst_count", result_count, 0);
    check("rst_in0", mult_input0, 16'h1234);
    check("rst_in1", mult_input1, 16'h5678);
    @(negedge clk);
    rst = 1'b0;
    op_valid = 1'b0;

    // nominal, then max operands, then backpressure
    fill(0); start_batch(); feed(1'b0); drain(DEPTH, 1'b0); finish_full(0, 1'b0);
    check("nominal_sum", exp_sum, 64'd4160);
    fill(1); start_batch(); feed(1'b0); drain(DEPTH, 1'b1); finish_full(0, 1'b0);
    fill(2); start_batch(); feed(1'b1); drain(DEPTH, 1'b1); finish_full(0, 1'b0);

    // watchdog after 40 beats
    fill(2); start_batch(); feed(1'b0); drain(40, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      VALID_memVal = 1'b0;
      n++;
      #1;
    end while (!result_valid && n < 1000);
    check("timeout_latency", n, TO + 1);
    check_result(exp_sum, 40, 1'b1, 0, 1'b0);

    // result stall with stray inputs
    fill(2); result_ready = 1'b0;
    start_batch(); feed(1'b0); drain(DEPTH, 1'b1); finish_full(15, 1'b1);
    result_ready = 1'b1;

    // reset mid-drain, then a fresh batch
    fill(2); start_batch(); feed(1'b0); drain(30, 1'b1);
    @(negedge clk);
    VALID_memVal = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    op_valid = 1'b1;
    RDY_mult = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_op_ready", op_ready, 0);
    check("mid_rst_en_mult", EN_mult, 0);
    check("mid_rst_blockread", EN_blockRead, 0);
    check("mid_rst_result_valid", result_valid, 0);
    check("mid_rst_data", result_data, 0);
    check("mid_rst_count", result_count, 0);
    check("mid_rst_err", err_timeout, 0);
    @(negedge clk);
    fill(2); start_batch(); feed(1'b0); drain(DEPTH, 1'b0); finish_full(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
